ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter: sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xF4 enable, 0xFF reset).
- It is the opposite direction of the existing keyboard_data receiver and shares the same PS2_CLK/PS2_DAT inout pins.
- It drives the lines only through open-drain "pull low" enables; the top level converts these to tristates.
- The receiver must ignore line activity while busy=1.

Parameters:
INHIBIT_CYCLES, 6000, clk cycles the host holds PS2_CLK low before the start bit (120 us at 50 MHz)
TIMEOUT_CYCLES, 750000, max clk cycles from START entry to ACK sample (15 ms at 50 MHz)

Ports:
clk  input  1  system clock (CLOCK_50 domain)
reset  input  1  synchronous, active-low reset (0 = reset)
tx_valid  input  1  request to send tx_data
tx_data  input  8  command byte
tx_ready  output  1  1 only in IDLE; a byte is accepted when tx_valid & tx_ready
busy  output  1  1 in every state except IDLE
tx_done  output  1  one-cycle pulse: byte acknowledged by device
tx_error  output  1  one-cycle pulse: NACK or timeout
ps2_clk_in  input  1  raw PS2_CLK pin level (asynchronous)
ps2_dat_in  input  1  raw PS2_DAT pin level (asynchronous)
ps2_clk_drive_low  output  1  1 = pull PS2_CLK low, 0 = release
ps2_dat_drive_low  output  1  1 = pull PS2_DAT low, 0 = release

Behaviour:
- Line inputs:
  - Both ps2_clk_in and ps2_dat_in pass through 2-flop synchronizers.
  - A falling edge (fe) is sync_clk_prev=1 and sync_clk=0, using the synchronized level only.
- All outputs are registered.
- Reset (reset=0 at a clk edge):
  - State goes to IDLE.
  - tx_ready=1 on the cycle after reset is released; busy=0, tx_done=0, tx_error=0.
  - Both drive_low outputs are 0.
  - Counters and the shift register are cleared.
  - Reset mid-frame releases both lines on the next cycle. No done or error pulse is produced.
- Accept: on tx_valid & tx_ready, latch the shift register = {parity, tx_data}, with parity = ~^tx_data (odd parity). Next state is INHIBIT.
- State machine:
  - IDLE: both lines released. Wait for accept.
  - INHIBIT:
    - ps2_clk_drive_low=1 and ps2_dat_drive_low=0.
    - Count INHIBIT_CYCLES cycles, then go to START.
  - START:
    - On entry, ps2_clk_drive_low=0 and ps2_dat_drive_low=1 (start bit 0), both in the same cycle.
    - The timeout counter is cleared and begins counting.
    - On fe, drive data bit 0 and go to DATA. Bit count = 1.
  - DATA:
    - The line value is driven as ps2_dat_drive_low = ~bit.
    - On each fe, drive the next bit, LSB first: bits 1..7 on fe 2..8, then parity on fe 9. After parity, go to STOP.
  - STOP: on fe 10, release data (stop bit = 1) and go to ACK.
  - ACK:
    - On fe 11, sample sync_dat.
    - sync_dat=0 is ACK: go to WAIT_IDLE.
    - sync_dat=1 is NACK: pulse tx_error, go to IDLE.
  - WAIT_IDLE: when sync_clk=1 and sync_dat=1, pulse tx_done and go to IDLE.
- Timeout:
  - In START, DATA, STOP or ACK, the timeout counter reaches TIMEOUT_CYCLES-1 without reaching WAIT_IDLE.
  - Response: release both lines, pulse tx_error, go to IDLE.
  - WAIT_IDLE shares the same counter, with the same response.
- Simultaneous events:
  - Timeout and fe in the same cycle: timeout wins.
  - tx_valid while busy: ignored. No queueing; tx_data changes are ignored after acceptance.
- Pulses: tx_done and tx_error are exactly one cycle wide and never asserted together. tx_ready returns to 1 in the same cycle as the pulse.
- Counter widths are sized by $clog2 of their parameter. Bit index is 4 bits.

Test Plan:
- Reset: hold reset=0 for 3 cycles with tx_valid=1 → drive_low both 0, tx_ready=1 after release, no pulses. Then tx_valid=1 with tx_data=0xED and INHIBIT_CYCLES=20 → ps2_clk_drive_low=1 for exactly 20 cycles, then clk released and dat pulled low in the same cycle.
- Device model clocking 11 falls (period 40 cycles) with ACK low on fall 11, byte 0xED → sampled line bits on fe 1..10 are 1,0,1,1,0,1,1,1, parity 1, stop 1. After lines idle: tx_done=1 for one cycle, tx_ready=1.
- Byte 0xF4 → data 0,0,1,0,1,1,1,1, parity 0, then tx_done.
- Device holds DAT high on fall 11 (NACK), byte 0xFF → tx_error single pulse, tx_done never, both lines released.
- TIMEOUT_CYCLES=500, device never clocks → tx_error exactly 500 cycles after START entry, ps2_dat_drive_low=0 on the following cycle.
- reset=0 after fe 5 of 0xED → both lines released next cycle, state IDLE, no pulses. A subsequent 0xF4 send completes with tx_done.

Source files
------------

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a start bit and shifts one
// odd-parity command byte out on device clock falls, then checks the device ACK.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_dat_drive_low
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [INH_W-1:0] INH_LAST = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_START     = 3'd2,
    ST_DATA      = 3'd3,
    ST_STOP      = 3'd4,
    ST_ACK       = 3'd5,
    ST_WAIT_IDLE = 3'd6
  } state_t;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  logic             clk_meta_r, sync_clk_r, sync_clk_prev_r;
  logic             dat_meta_r, sync_dat_r;
  logic             fe_s, tmo_active_s, timeout_s;
  state_t           state_r, state_s;
  logic [8:0]       shift_r, shift_s;
  logic [3:0]       bit_idx_r, bit_idx_s;
  logic [INH_W-1:0] inh_cnt_r, inh_cnt_s;
  logic [TMO_W-1:0] tmo_cnt_r, tmo_cnt_s;
  logic             dat_drive_s, done_s, error_s;

  assign fe_s         = sync_clk_prev_r & ~sync_clk_r;
  assign tmo_active_s = (state_r != ST_IDLE) && (state_r != ST_INHIBIT);
  assign timeout_s    = tmo_active_s && (tmo_cnt_r == TMO_LAST);

  // Two-flop synchronizers; reset to the idle-high bus level so no false fall appears.
  always_ff @(posedge clk) begin
    if (!reset) begin
      clk_meta_r      <= 1'b1;
      sync_clk_r      <= 1'b1;
      sync_clk_prev_r <= 1'b1;
      dat_meta_r      <= 1'b1;
      sync_dat_r      <= 1'b1;
    end else begin
      clk_meta_r      <= ps2_clk_in;
      sync_clk_r      <= clk_meta_r;
      sync_clk_prev_r <= sync_clk_r;
      dat_meta_r      <= ps2_dat_in;
      sync_dat_r      <= dat_meta_r;
    end
  end

  // Next-state, datapath and pulse decode; the timeout branch is taken before any fall.
  always_comb begin
    state_s     = state_r;
    shift_s     = shift_r;
    bit_idx_s   = bit_idx_r;
    inh_cnt_s   = inh_cnt_r;
    tmo_cnt_s   = tmo_active_s ? (tmo_cnt_r + TMO_W'(1)) : {TMO_W{1'b0}};
    dat_drive_s = ps2_dat_drive_low;
    done_s      = 1'b0;
    error_s     = 1'b0;
    if (timeout_s) begin
      state_s     = ST_IDLE;
      dat_drive_s = 1'b0;
      error_s     = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          dat_drive_s = 1'b0;
          if (tx_valid && tx_ready) begin
            state_s   = ST_INHIBIT;
            shift_s   = {odd_parity(tx_data), tx_data};
            inh_cnt_s = {INH_W{1'b0}};
            bit_idx_s = 4'd0;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_INHIBIT: begin
          dat_drive_s = 1'b0;
          if (inh_cnt_r == INH_LAST) begin
            state_s     = ST_START;
            dat_drive_s = 1'b1;
          end else begin
            inh_cnt_s = inh_cnt_r + INH_W'(1);
          end
        end
        ST_START: begin
          if (fe_s) begin
            dat_drive_s = ~shift_r[0];
            bit_idx_s   = 4'd1;
            state_s     = ST_DATA;
          end else begin
            dat_drive_s = 1'b1;
          end
        end
        ST_DATA: begin
          // Index 8 is the parity bit, driven on the ninth fall.
          if (fe_s) begin
            dat_drive_s = ~shift_r[bit_idx_r];
            bit_idx_s   = bit_idx_r + 4'd1;
            if (bit_idx_r == 4'd8) begin
              state_s = ST_STOP;
            end else begin
              state_s = ST_DATA;
            end
          end else begin
            state_s = ST_DATA;
          end
        end
        ST_STOP: begin
          if (fe_s) begin
            dat_drive_s = 1'b0;
            state_s     = ST_ACK;
          end else begin
            state_s = ST_STOP;
          end
        end
        ST_ACK: begin
          if (fe_s) begin
            if (!sync_dat_r) begin
              state_s = ST_WAIT_IDLE;
            end else begin
              error_s = 1'b1;
              state_s = ST_IDLE;
            end
          end else begin
            state_s = ST_ACK;
          end
        end
        ST_WAIT_IDLE: begin
          if (sync_clk_r && sync_dat_r) begin
            done_s  = 1'b1;
            state_s = ST_IDLE;
          end else begin
            state_s = ST_WAIT_IDLE;
          end
        end
        default: begin
          state_s     = ST_IDLE;
          dat_drive_s = 1'b0;
        end
      endcase
    end
  end

  // State, datapath and registered outputs, all decoded from the next state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r           <= ST_IDLE;
      shift_r           <= 9'd0;
      bit_idx_r         <= 4'd0;
      inh_cnt_r         <= {INH_W{1'b0}};
      tmo_cnt_r         <= {TMO_W{1'b0}};
      tx_ready          <= 1'b1;
      busy              <= 1'b0;
      tx_done           <= 1'b0;
      tx_error          <= 1'b0;
      ps2_clk_drive_low <= 1'b0;
      ps2_dat_drive_low <= 1'b0;
    end else begin
      state_r           <= state_s;
      shift_r           <= shift_s;
      bit_idx_r         <= bit_idx_s;
      inh_cnt_r         <= inh_cnt_s;
      tmo_cnt_r         <= tmo_cnt_s;
      tx_ready          <= (state_s == ST_IDLE);
      busy              <= (state_s != ST_IDLE);
      tx_done           <= done_s;
      tx_error          <= error_s;
      ps2_clk_drive_low <= (state_s == ST_INHIBIT);
      ps2_dat_drive_low <= dat_drive_s;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a clocking device model, bit and outcome
// scoreboards filled when a byte is offered and drained as the DUT produces them.
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TMO = 500;
  localparam logic [1:0] OUT_DONE = 2'b10;
  localparam logic [1:0] OUT_ERR  = 2'b01;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       dev_clk_low = 1'b0;
  logic       dev_dat_low = 1'b0;
  logic       tx_ready, busy, tx_done, tx_error, clk_drv, dat_drv;
  logic       ps2_clk_line, ps2_dat_line;

  int         tests = 0;
  int         fails = 0;
  logic [1:0] exp_q[$];
  logic       bit_q[$];

  assign ps2_clk_line = ~(clk_drv | dev_clk_low);
  assign ps2_dat_line = ~(dat_drv | dev_dat_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .busy(busy), .tx_done(tx_done), .tx_error(tx_error),
    .ps2_clk_in(ps2_clk_line), .ps2_dat_in(ps2_dat_line),
    .ps2_clk_drive_low(clk_drv), .ps2_dat_drive_low(dat_drv)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One cycle; any done/error pulse is matched against the outcome scoreboard.
  task automatic tick();
    logic [1:0] e;
    @(negedge clk);
    if (tx_done === 1'b1 || tx_error === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: done=%b error=%b, required none", tx_done, tx_error);
      end else begin
        e = exp_q.pop_front();
        if ({tx_done, tx_error} !== e) begin
          fails++;
          $display("FAIL outcome: {done,error}=%b, required %b", {tx_done, tx_error}, e);
        end
      end
      tests++;
      if (tx_ready !== 1'b1) begin
        fails++;
        $display("FAIL ready_with_pulse: tx_ready=%b, required 1", tx_ready);
      end
    end
  endtask

  task automatic push_frame(input logic [7:0] b, input int nbits, input logic [1:0] outcome,
                            input bit has_outcome);
    logic [9:0] bits;
    bits = {1'b1, ~^b, b};
    for (int i = 0; i < nbits; i++) bit_q.push_back(bits[i]);
    if (has_outcome) exp_q.push_back(outcome);
  endtask

  task automatic accept(input logic [7:0] b);
    tx_valid = 1'b1;
    tx_data  = b;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (!(dat_drv === 1'b1 && clk_drv === 1'b0) && n < 100) begin
      tick();
      n++;
    end
    tests++;
    if (n >= 100) begin
      fails++;
      $display("FAIL start_bit: clk_drv=%b dat_drv=%b, required 0/1 within 100 cycles", clk_drv, dat_drv);
    end
  endtask

  // Device: 11 falls, 20 cycles low/20 high, samples data just before each rise.
  task automatic device_frame(input bit ack_low, input int abort_fall);
    logic e;
    for (int i = 1; i <= 11; i++) begin
      dev_clk_low = 1'b1;
      if (i == abort_fall) begin
        repeat (10) tick();
        reset = 1'b0;
        dev_clk_low = 1'b0;
        tick();
        tests++;
        if (clk_drv !== 1'b0 || dat_drv !== 1'b0 || busy !== 1'b0 || tx_ready !== 1'b1) begin
          fails++;
          $display("FAIL midframe_reset: clk_drv=%b dat_drv=%b busy=%b ready=%b, required 0/0/0/1",
                   clk_drv, dat_drv, busy, tx_ready);
        end
        reset = 1'b1;
        return;
      end
      repeat (20) tick();
      if (i <= 10) begin
        tests++;
        if (bit_q.size() == 0) begin
          fails++;
          $display("FAIL bit_extra: fall %0d sampled %b, required no bit", i, ps2_dat_line);
        end else begin
          e = bit_q.pop_front();
          if (ps2_dat_line !== e) begin
            fails++;
            $display("FAIL line_bit: fall %0d got %b, required %b", i, ps2_dat_line, e);
          end
        end
      end
      dev_clk_low = 1'b0;
      if (i == 11) dev_dat_low = 1'b0;
      if (i == 10 && ack_low) dev_dat_low = 1'b1;
      repeat (20) tick();
    end
  endtask

  task automatic wait_outcome();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    tests++;
    if (exp_q.size() != 0 || bit_q.size() != 0) begin
      fails++;
      $display("FAIL drain: outcomes left=%0d bits left=%0d, required 0/0", exp_q.size(), bit_q.size());
      exp_q.delete();
      bit_q.delete();
    end
    tick();
    tests++;
    if (clk_drv !== 1'b0 || dat_drv !== 1'b0 || tx_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_after: clk_drv=%b dat_drv=%b ready=%b busy=%b, required 0/0/1/0",
               clk_drv, dat_drv, tx_ready, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tx_valid = 1'b1;
    tx_data = 8'hED;
    repeat (3) tick();
    tests++;
    if (clk_drv !== 1'b0 || dat_drv !== 1'b0 || busy !== 1'b0 || tx_done !== 1'b0 || tx_error !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: clk_drv=%b dat_drv=%b busy=%b done=%b err=%b, required all 0",
               clk_drv, dat_drv, busy, tx_done, tx_error);
    end
    tx_valid = 1'b0;
    reset = 1'b1;
    tick();
    tests++;
    if (tx_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release: ready=%b busy=%b, required 1/0", tx_ready, busy);
    end
  endtask

  task automatic test_inhibit_frame();
    int cnt = 0;
    push_frame(8'hED, 10, OUT_DONE, 1'b1);
    tx_valid = 1'b1;
    tx_data = 8'hED;
    tick();
    tx_data = 8'h00;
    while (clk_drv === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
    tx_valid = 1'b0;
    tests++;
    if (cnt != INH) begin
      fails++;
      $display("FAIL inhibit_len: %0d cycles, required %0d", cnt, INH);
    end
    tests++;
    if (clk_drv !== 1'b0 || dat_drv !== 1'b1) begin
      fails++;
      $display("FAIL start_handover: clk_drv=%b dat_drv=%b, required 0/1", clk_drv, dat_drv);
    end
    repeat (5) tick();
    device_frame(1'b1, 0);
    wait_outcome();
  endtask

  task automatic test_frame(input logic [7:0] b, input bit ack_low);
    push_frame(b, 10, ack_low ? OUT_DONE : OUT_ERR, 1'b1);
    accept(b);
    wait_start();
    repeat (5) tick();
    device_frame(ack_low, 0);
    wait_outcome();
  endtask

  task automatic test_timeout();
    int n = 0;
    exp_q.push_back(OUT_ERR);
    accept(8'h55);
    wait_start();
    while (tx_error !== 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    tests++;
    if (n != TMO) begin
      fails++;
      $display("FAIL timeout_delay: %0d cycles, required %0d", n, TMO);
    end
    tick();
    tests++;
    if (dat_drv !== 1'b0 || clk_drv !== 1'b0) begin
      fails++;
      $display("FAIL timeout_release: clk_drv=%b dat_drv=%b, required 0/0", clk_drv, dat_drv);
    end
    wait_outcome();
  endtask

  task automatic test_reset_mid_frame();
    push_frame(8'hED, 4, OUT_DONE, 1'b0);
    accept(8'hED);
    wait_start();
    repeat (5) tick();
    device_frame(1'b1, 5);
    repeat (10) tick();
    wait_outcome();
    test_frame(8'hF4, 1'b1);
  endtask

  initial begin
    test_reset();
    test_inhibit_frame();
    test_frame(8'hF4, 1'b1);
    test_frame(8'hFF, 1'b0);
    test_timeout();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
